seg7_scan_display: RTL and testbench
====================================

Name: seg7_scan_display

Overview:
Parametrised multiplexed seven-segment display driver for the CPU output path. It supports N digits, a double-buffered value and decimal-point mask loaded from the CPU bus, optional leading-zero suppression, and 16-level PWM brightness. It runs entirely on the system clock and advances on an internal prescaler tick, with no derived clock. All display outputs are registered and active-low.

Parameters:
DATA_WIDTH, 24, width of i_BUS.
NUM_DIGITS, 6, number of digits scanned (legal range 1..8); requires DATA_WIDTH >= NUM_DIGITS.
SCAN_DIVISOR, 3125, system clocks per scan tick (legal range >= 1).

Ports:
i_SYS_CLOCK  in  1  system clock; all logic on rising edge.
i_RESET_n  in  1  asynchronous, active-low reset.
i_BUS  in  DATA_WIDTH  CPU bus.
i_LOAD  in  1  sync; captures the value into the shadow register.
i_LOAD_DP  in  1  sync; captures i_BUS[NUM_DIGITS-1:0] into the shadow DP mask.
i_BRIGHTNESS  in  4  duty level, 0 (dark) to 15 (full on).
i_SUPPRESS_ZEROS  in  1  enables leading-zero blanking.
o_SEG  out  7  segments, [6]=A through [0]=G, active-low.
o_SEG_DP  out  1  decimal point, active-low.
o_SEL  out  NUM_DIGITS  digit selects, [0]=least significant digit, active-low.
o_FRAME  out  1  one-clock pulse when a new frame starts.

Behaviour:
- Reset, asynchronous and applied immediately:
  - o_SEG=all 1, o_SEG_DP=1, o_SEL=all 1, o_FRAME=0.
  - Shadow and active value = 0; shadow and active DP mask = 0; active brightness = 0.
  - Prescaler = 0, sub-slot s = 0, digit index d = 0.
- Prescaler:
  - Counts 0..SCAN_DIVISOR-1; tick is asserted when count = SCAN_DIVISOR-1, then the count wraps to 0.
  - With SCAN_DIVISOR=1, tick is asserted every clock.
- Scan sequence, evaluated only on tick:
  - s increments 0..15.
  - When s=15: s wraps to 0 and d advances; d=NUM_DIGITS-1 wraps to 0.
  - Digit slot = 16*SCAN_DIVISOR clocks; frame = NUM_DIGITS*16*SCAN_DIVISOR clocks.
- Frame commit, on the tick where d wraps to 0:
  - Shadow value, shadow DP mask and i_BRIGHTNESS are copied to the active registers.
  - o_FRAME is high for exactly one clock, aligned with the first output cycle of digit 0.
- Loads:
  - i_LOAD: shadow value <= i_BUS zero-extended or truncated to 4*NUM_DIGITS bits.
  - i_LOAD_DP: shadow DP mask <= i_BUS[NUM_DIGITS-1:0].
  - Both may be asserted in the same cycle.
  - A load in the same cycle as a commit: the commit takes the pre-load shadow contents; the new data is committed at the following frame.
- Lit condition for digit d:
  - (brightness = 15 or s < brightness) and not blanked.
  - Lit: o_SEL[d]=0 and all other selects = 1.
  - Dark: all selects = 1.
- Blanking:
  - Applies when i_SUPPRESS_ZEROS=1, d > 0, and active nibbles d..NUM_DIGITS-1 and DP bits d..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
- Segment codes (active-high, inverted onto o_SEG) for nibble value 0..F:
  7E 30 6D 79 33 5B 5F 70 7F 7B 77 1F 4E 3D 4F 47.
  - o_SEG_DP = inverse of active DP[d].
  - When no digit is lit, o_SEG and o_SEG_DP are driven all 1.
- Latency: outputs register the internal state of the previous clock (1-cycle lag). Selects never overlap; exactly zero or one select is low in any cycle.
- The first frame after reset displays all dark (active brightness = 0) until the first commit.

Test Plan:
1. Reset: assert i_RESET_n low mid-frame between clock edges -> same instant o_SEL=6'h3F, o_SEG=7'h7F, o_SEG_DP=1, o_FRAME=0; after release, output stays dark until the first o_FRAME.
2. Basic scan (SCAN_DIVISOR=2, brightness 15, load 24'h012345):
   - o_FRAME period = 192 clocks.
   - After the commit, o_SEL=6'h3E with o_SEG=7'h24 (digit "5") for 32 clocks.
   - Digit 5 shows o_SEG=7'h01 (digit "0").
3. Double buffer: during a frame showing 24'h012345, load 24'h00000F mid-frame -> digit 0 still shows 7'h24 until the next o_FRAME, then shows 7'h38 (digit "F").
4. Zero suppression: value 24'h000042, suppress=1 -> o_SEL[5:2] stay 1 for the whole frame. Then load DP mask 6'b001000 -> digits 3 and 2 lit showing 7'h01; digit 3 has o_SEG_DP=0.
5. Brightness (SCAN_DIVISOR=2): level 4 -> each select low exactly 8 consecutive clocks per 32-clock slot, starting at the slot start. Level 0 -> o_SEL all 1 for the entire frame.
6. Collision: assert i_LOAD with 24'hAAAAAA in the same cycle as the commit tick -> the frame after shows the old value; the following frame shows o_SEG=7'h08 (digit "A") on all digits.

Source files
------------

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: multiplexed N-digit seven-segment driver with double-buffered data, zero blanking and PWM brightness.
module seg7_scan_display #(
    parameter int DATA_WIDTH   = 24,
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIVISOR = 3125
) (
    input  logic                  i_SYS_CLOCK,
    input  logic                  i_RESET_n,
    input  logic [DATA_WIDTH-1:0] i_BUS,
    input  logic                  i_LOAD,
    input  logic                  i_LOAD_DP,
    input  logic [3:0]            i_BRIGHTNESS,
    input  logic                  i_SUPPRESS_ZEROS,
    output logic [6:0]            o_SEG,
    output logic                  o_SEG_DP,
    output logic [NUM_DIGITS-1:0] o_SEL,
    output logic                  o_FRAME
);
    localparam int VW = 4 * NUM_DIGITS;
    localparam int PW = SCAN_DIVISOR > 1 ? $clog2(SCAN_DIVISOR) : 1;
    localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    logic [PW-1:0]         pre_q, pre_d;
    logic [3:0]            sub_q, sub_d;
    logic [DW-1:0]         dig_q, dig_d;
    logic [VW-1:0]         shd_val_q, shd_val_d, act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0] shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
    logic [3:0]            act_br_q, act_br_d;
    logic                  start_q, start_d;
    logic [6:0]            seg_q, seg_d;
    logic                  seg_dp_q, seg_dp_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  frame_q, frame_d;
    logic                  tick, commit, blank, lit, tz;
    logic [NUM_DIGITS-1:0] tail_zero;
    logic [3:0]            nib;

    always_comb begin
        tick      = pre_q == PW'(SCAN_DIVISOR - 1);
        commit    = tick && sub_q == 4'hF && dig_q == DW'(NUM_DIGITS - 1);
        pre_d     = tick ? '0 : pre_q + 1'b1;
        sub_d     = tick ? sub_q + 1'b1 : sub_q;
        dig_d     = (tick && sub_q == 4'hF) ? (dig_q == DW'(NUM_DIGITS - 1) ? '0 : dig_q + 1'b1) : dig_q;
        shd_val_d = i_LOAD ? VW'(i_BUS) : shd_val_q;
        shd_dp_d  = i_LOAD_DP ? i_BUS[NUM_DIGITS-1:0] : shd_dp_q;
        // Commit samples the registered shadow, so a same-cycle load waits one frame
        act_val_d = commit ? shd_val_q : act_val_q;
        act_dp_d  = commit ? shd_dp_q : act_dp_q;
        act_br_d  = commit ? i_BRIGHTNESS : act_br_q;
        start_d   = commit;
        tz        = 1'b1;
        tail_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            tz           = tz & (act_val_q[4*i +: 4] == 4'h0) & ~act_dp_q[i];
            tail_zero[i] = tz;
        end
        nib      = act_val_q[{dig_q, 2'b00} +: 4];
        blank    = i_SUPPRESS_ZEROS && dig_q != '0 && tail_zero[dig_q];
        lit      = (act_br_q == 4'hF || sub_q < act_br_q) && !blank;
        sel_d    = lit ? ~(NUM_DIGITS'(1) << dig_q) : '1;
        seg_d    = lit ? ~SEG_LUT[nib] : '1;
        seg_dp_d = lit ? ~act_dp_q[dig_q] : 1'b1;
        frame_d  = start_q;
    end

    always_ff @(posedge i_SYS_CLOCK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            pre_q     <= '0;
            sub_q     <= '0;
            dig_q     <= '0;
            shd_val_q <= '0;
            act_val_q <= '0;
            shd_dp_q  <= '0;
            act_dp_q  <= '0;
            act_br_q  <= '0;
            start_q   <= 1'b0;
            seg_q     <= '1;
            seg_dp_q  <= 1'b1;
            sel_q     <= '1;
            frame_q   <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            sub_q     <= sub_d;
            dig_q     <= dig_d;
            shd_val_q <= shd_val_d;
            act_val_q <= act_val_d;
            shd_dp_q  <= shd_dp_d;
            act_dp_q  <= act_dp_d;
            act_br_q  <= act_br_d;
            start_q   <= start_d;
            seg_q     <= seg_d;
            seg_dp_q  <= seg_dp_d;
            sel_q     <= sel_d;
            frame_q   <= frame_d;
        end
    end

    assign o_SEG    = seg_q;
    assign o_SEG_DP = seg_dp_q;
    assign o_SEL    = sel_q;
    assign o_FRAME  = frame_q;
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: scoreboard plus vector-table bench for seg7_scan_display at SCAN_DIVISOR=2.
module tb_seg7_scan_display;
    localparam int N  = 6;
    localparam int SD = 2;
    localparam int F  = 16 * SD * N;
    localparam logic [6:0] LUT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] bus = '0;
    logic        ld = 1'b0, ld_dp = 1'b0, supp = 1'b0;
    logic [3:0]  br = '0;
    logic [6:0]  seg;
    logic        seg_dp, frame;
    logic [5:0]  sel;

    always #5 clk = ~clk;

    seg7_scan_display #(.DATA_WIDTH(24), .NUM_DIGITS(N), .SCAN_DIVISOR(SD)) dut (
        .i_SYS_CLOCK(clk), .i_RESET_n(rst_n), .i_BUS(bus), .i_LOAD(ld), .i_LOAD_DP(ld_dp),
        .i_BRIGHTNESS(br), .i_SUPPRESS_ZEROS(supp), .o_SEG(seg), .o_SEG_DP(seg_dp),
        .o_SEL(sel), .o_FRAME(frame)
    );

    typedef struct packed {
        logic [5:0] sel;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
    } out_t;

    typedef struct packed {
        logic [23:0] val;
        logic [5:0]  dp;
        logic [3:0]  br;
        logic        supp;
        logic [2:0]  digit;
        logic [5:0]  sel;
        logic [6:0]  seg;
        logic        sdp;
    } vec_t;

    out_t        exp_q[$];
    vec_t        vt[$];
    int          n_checks = 0, n_fail = 0;
    int unsigned t = 0;
    logic [23:0] m_shd = '0, m_act = '0;
    logic [5:0]  m_shd_dp = '0, m_act_dp = '0;
    logic [3:0]  m_br = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected output for the state reached after t clocks, computed from absolute position
    function automatic out_t model_out();
        out_t o;
        int   tk, s, d;
        logic blank, lit;
        tk      = int'(t) / SD;
        s       = tk % 16;
        d       = (tk / 16) % N;
        blank   = supp && d > 0 && (m_act >> (4 * d)) == 0 && (m_act_dp >> d) == 0;
        lit     = (m_br == 4'hF || s < int'(m_br)) && !blank;
        o.sel   = lit ? ~(6'd1 << d) : 6'h3F;
        o.seg   = lit ? ~LUT[m_act[4*d +: 4]] : 7'h7F;
        o.dp    = lit ? ~m_act_dp[d] : 1'b1;
        o.frame = t > 0 && t % F == 0;
        return o;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t        <= 0;
            m_shd    <= '0;
            m_act    <= '0;
            m_shd_dp <= '0;
            m_act_dp <= '0;
            m_br     <= '0;
            exp_q.delete();
        end else begin
            exp_q.push_back(model_out());
            if ((t + 1) % F == 0) begin
                m_act    <= m_shd;
                m_act_dp <= m_shd_dp;
                m_br     <= br;
            end
            if (ld) m_shd <= bus;
            if (ld_dp) m_shd_dp <= bus[5:0];
            t <= t + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n)
            chk("reset_outputs", 32'({sel, seg, seg_dp, frame}), 32'({6'h3F, 7'h7F, 1'b1, 1'b0}));
        else if (exp_q.size() > 0)
            chk("scoreboard", 32'({sel, seg, seg_dp, frame}), 32'(exp_q.pop_front()));
    end

    task automatic wait_frame(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!frame && cyc < 600);
        if (!frame) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: no o_FRAME within %0d clocks", cyc);
        end
    endtask

    task automatic load(input logic [23:0] val, input logic [5:0] dp);
        @(negedge clk);
        bus = val;
        ld  = 1'b1;
        @(negedge clk);
        ld    = 1'b0;
        bus   = {18'h0, dp};
        ld_dp = 1'b1;
        @(negedge clk);
        ld_dp = 1'b0;
    endtask

    initial begin
        int cyc, cnt, run;
        bit in_run;
        vt.push_back({24'h012345, 6'h00, 4'hF, 1'b0, 3'd0, 6'h3E, 7'h24, 1'b1});
        vt.push_back({24'h012345, 6'h00, 4'hF, 1'b0, 3'd5, 6'h1F, 7'h01, 1'b1});
        vt.push_back({24'h012345, 6'h00, 4'hF, 1'b0, 3'd2, 6'h3B, 7'h06, 1'b1});
        vt.push_back({24'h00000F, 6'h00, 4'hF, 1'b0, 3'd0, 6'h3E, 7'h38, 1'b1});
        vt.push_back({24'h000042, 6'h00, 4'hF, 1'b1, 3'd2, 6'h3F, 7'h7F, 1'b1});
        vt.push_back({24'h000042, 6'h00, 4'hF, 1'b1, 3'd1, 6'h3D, 7'h4C, 1'b1});
        vt.push_back({24'h000042, 6'h08, 4'hF, 1'b1, 3'd3, 6'h37, 7'h01, 1'b0});
        vt.push_back({24'h000042, 6'h08, 4'hF, 1'b1, 3'd2, 6'h3B, 7'h01, 1'b1});
        vt.push_back({24'h000042, 6'h00, 4'hF, 1'b0, 3'd5, 6'h1F, 7'h01, 1'b1});
        vt.push_back({24'hAAAAAA, 6'h00, 4'hF, 1'b0, 3'd4, 6'h2F, 7'h08, 1'b1});
        vt.push_back({24'hAAAAAA, 6'h00, 4'h0, 1'b0, 3'd4, 6'h3F, 7'h7F, 1'b1});
        vt.push_back({24'h000080, 6'h00, 4'hF, 1'b0, 3'd1, 6'h3D, 7'h00, 1'b1});

        repeat (3) @(negedge clk);
        br    = 4'hF;
        rst_n = 1'b1;
        load(24'h012345, 6'h00);
        cnt = 0;
        cyc = 0;
        while (!frame && cyc < 600) begin
            if (sel != 6'h3F) cnt++;
            @(negedge clk);
            cyc++;
        end
        chk("dark_before_first_frame", 32'(cnt), 0);
        chk("first_frame_seen", 32'(frame), 1);

        wait_frame(cyc);
        chk("frame_period", 32'(cyc), 192);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (sel == 6'h3E && seg == 7'h24) cnt++;
            @(negedge clk);
        end
        chk("digit0_slot_len", 32'(cnt), 32);
        chk("digit1_start_sel", 32'(sel), 'h3D);

        load(24'h00000F, 6'h00);
        wait_frame(cyc);
        chk("dbuf_new_seg", 32'(seg), 'h38);
        chk("dbuf_new_sel", 32'(sel), 'h3E);

        foreach (vt[k]) begin
            load(vt[k].val, vt[k].dp);
            br   = vt[k].br;
            supp = vt[k].supp;
            wait_frame(cyc);
            wait_frame(cyc);
            repeat (int'(vt[k].digit) * 32 + 1) @(negedge clk);
            chk($sformatf("vec%0d_sel", k), 32'(sel), 32'(vt[k].sel));
            chk($sformatf("vec%0d_seg", k), 32'(seg), 32'(vt[k].seg));
            chk($sformatf("vec%0d_dp", k), 32'(seg_dp), 32'(vt[k].sdp));
        end

        load(24'h00000F, 6'h00);
        br   = 4'd4;
        supp = 1'b0;
        wait_frame(cyc);
        wait_frame(cyc);
        cnt    = 0;
        run    = 0;
        in_run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (sel == 6'h3E) cnt++;
            if (sel == 6'h3E && in_run) run++;
            else in_run = 1'b0;
            @(negedge clk);
        end
        chk("br4_total_low", 32'(cnt), 8);
        chk("br4_run_from_start", 32'(run), 8);

        br = 4'd0;
        wait_frame(cyc);
        wait_frame(cyc);
        cnt = 0;
        for (int i = 0; i < F; i++) begin
            if (sel != 6'h3F) cnt++;
            @(negedge clk);
        end
        chk("br0_dark_frame", 32'(cnt), 0);

        load(24'h000042, 6'h00);
        br   = 4'hF;
        supp = 1'b1;
        wait_frame(cyc);
        wait_frame(cyc);
        cnt = 0;
        for (int i = 0; i < F; i++) begin
            if (sel[5:2] != 4'hF) cnt++;
            @(negedge clk);
        end
        chk("suppress_upper_dark", 32'(cnt), 0);

        supp = 1'b0;
        load(24'h012345, 6'h00);
        wait_frame(cyc);
        wait_frame(cyc);
        repeat (190) @(negedge clk);
        bus = 24'hAAAAAA;
        ld  = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        wait_frame(cyc);
        chk("collision_gap", 32'(cyc), 1);
        chk("collision_old_value", 32'(seg), 'h24);
        wait_frame(cyc);
        cnt = 0;
        for (int i = 0; i < F; i++) begin
            if (seg == 7'h08 && sel != 6'h3F) cnt++;
            @(negedge clk);
        end
        chk("collision_new_value", 32'(cnt), F);

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_sel", 32'(sel), 'h3F);
        chk("async_reset_seg", 32'(seg), 'h7F);
        chk("async_reset_dp", 32'(seg_dp), 1);
        chk("async_reset_frame", 32'(frame), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_frame(cyc);
        chk("post_reset_first_frame", 32'(cyc), 193);
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
